// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//
// MEM stage of the pipeline. Takes the EX/MEM register outputs, performs the
// data-memory access over a variable-latency req/ack bus, builds byte enables
// and lane-replicated store data, extracts/extends load data and registers the
// result into the MEM/WB outputs. mem_stall holds upstream stages (and so the
// EX/MEM inputs) stable while an access is outstanding.
//
// Bus handshake: dm_req rises at the edge that leaves IDLE with an aligned
// access and stays high, together with dm_we/dm_addr/dm_be/dm_wdata, unchanged
// until the first rising edge at which dm_ack is sampled high (or the access
// times out); a transfer completes exactly on that edge. dm_ack is ignored
// while no request is outstanding.
//
// Ports:
//   clock, reset             rising-edge clock, synchronous active-low reset
//   ddpc4, dbusw, ddata2     PC+4, ALU result/address, store data (EX/MEM)
//   drw, nnreg_write         destination register, register write enable
//   nnmem_write, mmemtoreg   store / load
//   nns_data_write           access size: 00 word, 01 half, 10 byte, 11 word
//   dm_req/we/addr/be/wdata  data-memory request side
//   dm_ack, dm_rdata         data-memory completion side
//   mem_stall                combinational hold for upstream stages
//   wb_*                     MEM/WB register outputs
//   misalign, bus_err        one-cycle error pulses
//   mem_fault                sticky error flag, cleared only by reset
//   dbg_state                current FSM state (0 IDLE, 1 BUSY)
// -----------------------------------------------------------------------------
module mem_access_stage #(
  parameter int unsigned TIMEOUT     = 16,
  parameter bit          LOAD_SIGNED = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ddpc4,
  input  logic [31:0] dbusw,
  input  logic [31:0] ddata2,
  input  logic [4:0]  drw,
  input  logic        nnreg_write,
  input  logic        nnmem_write,
  input  logic [1:0]  nns_data_write,
  input  logic        mmemtoreg,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        mem_stall,
  output logic [31:0] wb_pc4,
  output logic [31:0] wb_alu,
  output logic [31:0] wb_mdata,
  output logic [4:0]  wb_rw,
  output logic        wb_reg_write,
  output logic        wb_memtoreg,
  output logic        misalign,
  output logic        bus_err,
  output logic        mem_fault,
  output logic        dbg_state
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;

  // Decode of the incoming operation
  logic access, is_half, is_byte, is_word, misaligned, cnt_last;

  assign access     = nnmem_write | mmemtoreg;
  assign is_half    = (nns_data_write == 2'b01);
  assign is_byte    = (nns_data_write == 2'b10);
  assign is_word    = ~is_half & ~is_byte;
  assign misaligned = (is_half & dbusw[0]) | (is_word & (|dbusw[1:0]));
  assign cnt_last   = (cnt_q == CNT_LAST);
  assign dbg_state  = (state_q == BUSY);

  // Per-cycle actions chosen by the output process
  logic start_acc, take_mis, pass_thru, complete, timeout, wait_cyc;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (access && !misaligned) state_d = BUSY;
      BUSY: if (dm_ack || cnt_last)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output / action decode. An ack in the timeout cycle is a normal
  // completion, so dm_ack is tested before the counter.
  // ---------------------------------------------------------------------------
  always_comb begin
    start_acc = 1'b0;
    take_mis  = 1'b0;
    pass_thru = 1'b0;
    complete  = 1'b0;
    timeout   = 1'b0;
    wait_cyc  = 1'b0;
    mem_stall = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!access) begin
          pass_thru = 1'b1;
        end else if (misaligned) begin
          take_mis = 1'b1;
        end else begin
          start_acc = 1'b1;
          mem_stall = 1'b1;
        end
      end
      BUSY: begin
        if (dm_ack) begin
          complete = 1'b1;
        end else if (cnt_last) begin
          timeout = 1'b1;
        end else begin
          wait_cyc  = 1'b1;
          mem_stall = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Byte enables and store-data lanes (little-endian)
  // ---------------------------------------------------------------------------
  logic [3:0]  be_d;
  logic [31:0] wdata_d;

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = ddata2;
    if (is_byte) begin
      be_d    = 4'b0001 << dbusw[1:0];
      wdata_d = {4{ddata2[7:0]}};
    end else if (is_half) begin
      be_d    = dbusw[1] ? 4'b1100 : 4'b0011;
      wdata_d = {2{ddata2[15:0]}};
    end
  end

  // ---------------------------------------------------------------------------
  // Load extraction: pick the addressed lane, then sign/zero extend
  // ---------------------------------------------------------------------------
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;

  always_comb begin
    lane_byte = dm_rdata[{dbusw[1:0], 3'b000} +: 8];
    lane_half = dbusw[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    load_data = dm_rdata;
    if (is_byte)      load_data = {{24{LOAD_SIGNED & lane_byte[7]}}, lane_byte};
    else if (is_half) load_data = {{16{LOAD_SIGNED & lane_half[15]}}, lane_half};
  end

  // ---------------------------------------------------------------------------
  // Bus request, timeout counter and MEM/WB registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      dm_req       <= 1'b0;
      dm_we        <= 1'b0;
      dm_addr      <= 32'h0;
      dm_be        <= 4'h0;
      dm_wdata     <= 32'h0;
      cnt_q        <= '0;
      wb_pc4       <= 32'h0;
      wb_alu       <= 32'h0;
      wb_mdata     <= 32'h0;
      wb_rw        <= 5'h0;
      wb_reg_write <= 1'b0;
      wb_memtoreg  <= 1'b0;
      misalign     <= 1'b0;
      bus_err      <= 1'b0;
      mem_fault    <= 1'b0;
    end else begin
      misalign <= 1'b0;
      bus_err  <= 1'b0;

      if (start_acc) begin
        dm_req       <= 1'b1;
        dm_we        <= nnmem_write;
        dm_addr      <= {dbusw[31:2], 2'b00};
        dm_be        <= be_d;
        dm_wdata     <= wdata_d;
        cnt_q        <= '0;
        wb_reg_write <= 1'b0;   // bubble while the access is outstanding
      end

      if (wait_cyc) begin
        cnt_q        <= cnt_q + CNT_W'(1);
        wb_reg_write <= 1'b0;
      end

      if (pass_thru || take_mis || complete || timeout) begin
        wb_pc4      <= ddpc4;
        wb_alu      <= dbusw;
        wb_rw       <= drw;
        wb_memtoreg <= mmemtoreg;
      end

      if (pass_thru) begin
        wb_reg_write <= nnreg_write;
        wb_mdata     <= 32'h0;
      end

      if (take_mis) begin
        misalign     <= 1'b1;
        wb_reg_write <= 1'b0;
        wb_mdata     <= 32'h0;
      end

      if (complete) begin
        dm_req       <= 1'b0;
        dm_we        <= 1'b0;
        wb_reg_write <= nnreg_write;
        wb_mdata     <= nnmem_write ? 32'h0 : load_data;
      end

      if (timeout) begin
        dm_req       <= 1'b0;
        dm_we        <= 1'b0;
        bus_err      <= 1'b1;
        mem_fault    <= 1'b1;
        wb_reg_write <= 1'b0;
        wb_mdata     <= 32'h0;
      end
    end
  end

endmodule
